// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32I byte/half/word loads and stores over a word-only RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_Adr,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic        mem_OE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_wd;
  logic        r_err;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  // All legality is decided on the raw request so an illegal access never touches memory.
  always_comb begin
    w_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
         || (req_we && req_funct3[2])
         || ((req_funct3[1:0] == 2'b01) && req_addr[0])
         || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
         || ({2'b00, req_addr[31:2]} >= c_mem_words);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_err)                          w_next = RESP;
          else if (!req_we)                   w_next = LOAD;
          else if (req_funct3[1:0] == 2'b10)  w_next = STORE;
          else                                w_next = RMW_RD;
        end
      end
      LOAD:    w_next = RESP;
      STORE:   w_next = RESP;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_half = r_addr[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (r_addr[1:0])
      2'd0:    w_byte = mem_RD[7:0];
      2'd1:    w_byte = mem_RD[15:8];
      2'd2:    w_byte = mem_RD[23:16];
      default: w_byte = mem_RD[31:24];
    endcase
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = mem_RD;
    endcase
  end

  always_comb begin
    w_merged = mem_RD;
    if (r_funct3[0]) w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    else             w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 16'd0;
      r_rdata  <= 32'd0;
      r_wd     <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && req) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata[15:0];
        r_wd     <= req_wdata;
        r_err    <= w_err;
      end
      if (r_state == LOAD)   r_rdata <= w_load_val;
      if (r_state == RMW_RD) r_wd    <= w_merged;
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == RESP);
  assign err     = (r_state == RESP) && r_err;
  assign rdata   = r_rdata;
  assign mem_Adr = {2'b00, r_addr[31:2]};
  assign mem_WD  = r_wd;
  assign mem_WE  = (r_state == STORE) || (r_state == RMW_WR);
  assign mem_OE  = (r_state == LOAD) || (r_state == RMW_RD);

endmodule
`default_nettype wire
